spcore_ctrl: RTL and testbench
==============================

SPCORE_CTRL -- requirements
Module: spcore_ctrl

Interface
REQ-001 Parameter IW, default 32: instruction word width in bits.
REQ-002 Parameter OPW, default 4: opcode field width in bits.
REQ-003 Port clk  in  1: single clock; all state changes on rising edge.
REQ-004 Port reset  in  1: asynchronous, active-low reset; the block is in reset while reset=0.
REQ-005 Port en  in  1: the FSM advances only while en=1, and holds state while en=0.
REQ-006 Port instr  in  IW: instruction word; [31:28] opcode, [27:24] x, [23:20] y, [19:16] z, [15:0] imm.
REQ-007 Port instr_valid  in  1: the instruction on instr is valid.
REQ-008 Port instr_ready  out  1: the block can accept an instruction.
REQ-009 Ports x, y, z  out  4 each: register-file destination and source indices for spcore.
REQ-010 Port I  out  16: immediate value to spcore.
REQ-011 Port aluc  out  4: ALU control to spcore.
REQ-012 Port s2  out  2: write-back mux select to spcore.
REQ-013 Port reg_we  out  1: register-file write enable.
REQ-014 Port mem_we  out  1: data-memory write enable.
REQ-015 Port done  out  1: one-cycle pulse when an instruction retires.
REQ-016 Port err  out  1: one-cycle pulse when an illegal opcode is accepted.
REQ-017 Port halted  out  1: high after HALT retires.

Function
REQ-018 Opcodes: 0 NOP, 1 LOADI, 2 ADD, 3 MUL, 4 MAD, 5 STORE, 6 LOAD, F HALT; all other values are illegal.
REQ-019 FSM states: IDLE, READ, EXEC, MEM, WB, HALTED.
REQ-020 instr_ready=1 only in IDLE with en=1; an instruction is accepted when instr_ready=1 and instr_valid=1, and the block latches instr on that edge.
REQ-021 Instruction paths after acceptance: state goes to READ; fields drive x, y, z, I from READ onward and stay stable until retirement.
REQ-022 LOADI: READ->WB; in WB, s2=MuxD_fromI, aluc=ALUC_CLEAR, reg_we=1.
REQ-023 ADD/MUL/MAD: READ->EXEC->WB; in EXEC and WB, aluc=ALUC_ADD/ALUC_MUL/ALUC_MAD and s2=MuxD_fromALU; reg_we=1 only in WB.
REQ-024 STORE: READ->MEM; in MEM, mem_we=1 for exactly one cycle.
REQ-025 LOAD: READ->MEM->WB; in WB, s2=MuxD_fromMem and reg_we=1.
REQ-026 NOP and illegal opcodes: READ->IDLE with no write enables; illegal opcodes also pulse err in READ.
REQ-027 HALT: READ->HALTED; halted=1 and instr_ready=0 until reset.
REQ-028 done pulses in the final cycle of each instruction (WB, MEM for STORE, READ for NOP/illegal/HALT); the next state is IDLE, or HALTED for HALT.
REQ-029 Latency from acceptance edge to done: LOADI 2, ADD/MUL/MAD 3, STORE 2, LOAD 3, NOP 1 cycles.
REQ-030 When en=0: state and fields hold; reg_we, mem_we, done and err are forced to 0; when en returns to 1, execution resumes in the held state.
REQ-031 reg_we and mem_we are never both 1.
REQ-032 Outputs are registered or decoded from state only, with no combinational path from instr to the outputs.
REQ-033 instr_valid asserted outside IDLE is ignored; it is not queued.

Reset
REQ-034 Reset values: state=IDLE, x=y=z=0, I=0, aluc=ALUC_CLEAR, s2=MuxD_fromALU, reg_we=0, mem_we=0, done=0, err=0, halted=0, instr_ready=0 while reset=0.
REQ-035 Reset mid-instruction abandons the instruction immediately with no partial write; instr_ready=1 on the first en=1 cycle after reset deasserts.

Structure
REQ-036 Opcode values, ALUC_* codes, MuxD_* selects (including the new MuxD_fromMem) and state encodings live in the shared constants file.
REQ-037 No sub-module is required; the optional decode function is named spcore_decode.

Verification
REQ-038 LOADI x=0 imm=11 -> reg_we=1 exactly 2 cycles after acceptance with s2=MuxD_fromI and I=11; done coincident; through spcore, R[0]=11.
REQ-039 LOADI R0=11, LOADI R1=20, ADD x=2 y=0 z=1, MAD x=2 y=0 z=1, MUL x=2 y=0 z=1 -> R2=31, then 251, then 220; each ADD/MUL/MAD has 3-cycle latency.
REQ-040 STORE x=2 y=0 -> mem_we pulses once in MEM with reg_we=0 and done coincident.
REQ-041 en dropped to 0 during EXEC of ADD for 3 cycles -> no enable pulses while en=0; WB occurs on the first cycle after en returns, with R2 correct.
REQ-042 Opcode 0x9 -> err and done pulse together in READ with no writes; HALT -> halted=1, and instr_ready stays 0 for 10 cycles despite instr_valid=1.
REQ-043 reset=0 asserted during EXEC of ADD -> no reg_we pulse and outputs at reset values; after release, a new LOADI is accepted and retires correctly.

Source files
------------

// File: rtl/spcore_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spcore_ctrl_pkg
// Shared constants for the spcore controller and anything that talks to it:
//   - opcode values carried in instr[31:28]
//   - ALU control codes (ALUC_*) driven on aluc
//   - write-back mux selects (MuxD_*) driven on s2
//   - controller FSM state encoding
// Small decode helpers used by the controller next-state and output logic
// are also provided here.
// ---------------------------------------------------------------------------
package spcore_ctrl_pkg;

  // Opcodes; every value not listed here is illegal
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOADI = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_MAD   = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_LOAD  = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU control codes
  localparam logic [3:0] ALUC_CLEAR = 4'd0;
  localparam logic [3:0] ALUC_ADD   = 4'd1;
  localparam logic [3:0] ALUC_MUL   = 4'd2;
  localparam logic [3:0] ALUC_MAD   = 4'd3;

  // Write-back data selects
  localparam logic [1:0] MuxD_fromALU = 2'd0;
  localparam logic [1:0] MuxD_fromI   = 2'd1;
  localparam logic [1:0] MuxD_fromMem = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  // State that follows READ for a given opcode. NOP and illegal opcodes
  // retire in READ and go straight back to IDLE.
  function automatic state_e spcore_decode(input logic [3:0] op);
    state_e nxt;
    case (op)
      OP_LOADI:                 nxt = ST_WB;
      OP_ADD, OP_MUL, OP_MAD:   nxt = ST_EXEC;
      OP_STORE, OP_LOAD:        nxt = ST_MEM;
      OP_HALT:                  nxt = ST_HALTED;
      default:                  nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

  function automatic logic spcore_is_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_NOP, OP_LOADI, OP_ADD, OP_MUL, OP_MAD,
      OP_STORE, OP_LOAD, OP_HALT: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // ALU operation for the arithmetic opcodes; CLEAR for everything else
  function automatic logic [3:0] spcore_aluc(input logic [3:0] op);
    logic [3:0] a;
    case (op)
      OP_ADD:  a = ALUC_ADD;
      OP_MUL:  a = ALUC_MUL;
      OP_MAD:  a = ALUC_MAD;
      default: a = ALUC_CLEAR;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/spcore_ctrl.sv
// ---------------------------------------------------------------------------
// spcore_ctrl
// Multi-cycle instruction sequencer for the spcore datapath.
// Accepts one instruction at a time from IDLE, walks it through
// READ / EXEC / MEM / WB as its opcode requires, and drives the datapath
// controls. HALT parks the block in HALTED until reset.
//
// Ports
//   clk          in   clock, rising edge active
//   reset        in   asynchronous active-low reset
//   en           in   advance enable; the FSM holds and pulses are masked when 0
//   instr        in   IW  instruction word {op, x, y, z, imm[15:0]}
//   instr_valid  in   instr carries a valid instruction
//   instr_ready  out  block can accept an instruction (IDLE and en)
//   x, y, z      out  4 each, destination / source register indices
//   I            out  16, immediate
//   aluc         out  4, ALU control
//   s2           out  2, write-back mux select
//   reg_we       out  register-file write enable
//   mem_we       out  data-memory write enable
//   done         out  one-cycle pulse in the retiring cycle
//   err          out  one-cycle pulse when an illegal opcode is read
//   halted       out  high once HALT has retired
// ---------------------------------------------------------------------------
module spcore_ctrl
  import spcore_ctrl_pkg::*;
#(
  parameter int IW  = 32,
  parameter int OPW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [3:0]    x,
  output logic [3:0]    y,
  output logic [3:0]    z,
  output logic [15:0]   I,
  output logic [3:0]    aluc,
  output logic [1:0]    s2,
  output logic          reg_we,
  output logic          mem_we,
  output logic          done,
  output logic          err,
  output logic          halted
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [3:0]     x_q, x_d, y_q, y_d, z_q, z_d;
  logic [15:0]    imm_q, imm_d;
  logic           reg_we_q, reg_we_d;
  logic           mem_we_q, mem_we_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           halted_q, halted_d;
  logic [3:0]     aluc_q, aluc_d;
  logic [1:0]     s2_q, s2_d;

  // Next-state and instruction latch; everything holds while en is low
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    imm_d   = imm_q;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            state_d = ST_READ;
            op_d    = instr[IW-1 -: OPW];
            x_d     = instr[IW-OPW-1 -: 4];
            y_d     = instr[IW-OPW-5 -: 4];
            z_d     = instr[IW-OPW-9 -: 4];
            imm_d   = instr[15:0];
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_READ:   state_d = spcore_decode(op_q);
        ST_EXEC:   state_d = ST_WB;
        ST_MEM: begin
          if (op_q == OP_LOAD) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WB:     state_d = ST_IDLE;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output values for the state being entered, so the registered outputs
  // line up with the state register rather than lagging it by a cycle
  always_comb begin
    reg_we_d = (state_d == ST_WB);
    mem_we_d = (state_d == ST_MEM) && (op_d == OP_STORE);
    err_d    = (state_d == ST_READ) && !spcore_is_legal(op_d);
    halted_d = (state_d == ST_HALTED);
    // READ is the last cycle for opcodes that leave READ for IDLE/HALTED
    done_d   = reg_we_d || mem_we_d ||
               ((state_d == ST_READ) &&
                ((spcore_decode(op_d) == ST_IDLE) || (spcore_decode(op_d) == ST_HALTED)));
    if ((state_d == ST_EXEC) || (state_d == ST_WB)) begin
      aluc_d = spcore_aluc(op_d);
    end else begin
      aluc_d = ALUC_CLEAR;
    end
    if (state_d == ST_WB) begin
      case (op_d)
        OP_LOADI: s2_d = MuxD_fromI;
        OP_LOAD:  s2_d = MuxD_fromMem;
        default:  s2_d = MuxD_fromALU;
      endcase
    end else begin
      s2_d = MuxD_fromALU;
    end
  end

  // FSM state, latched instruction fields and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      x_q      <= 4'd0;
      y_q      <= 4'd0;
      z_q      <= 4'd0;
      imm_q    <= 16'd0;
      reg_we_q <= 1'b0;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
      aluc_q   <= ALUC_CLEAR;
      s2_q     <= MuxD_fromALU;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      imm_q    <= imm_d;
      reg_we_q <= reg_we_d;
      mem_we_q <= mem_we_d;
      done_q   <= done_d;
      err_q    <= err_d;
      halted_q <= halted_d;
      aluc_q   <= aluc_d;
      s2_q     <= s2_d;
    end
  end

  // Strobes are masked by en so a stalled cycle never writes or retires;
  // ready also drops while reset is held so nothing is offered in reset.
  assign instr_ready = (state_q == ST_IDLE) && en && reset;
  assign reg_we      = reg_we_q && en;
  assign mem_we      = mem_we_q && en;
  assign done        = done_q && en;
  assign err         = err_q && en;
  assign halted      = halted_q;
  assign x           = x_q;
  assign y           = y_q;
  assign z           = z_q;
  assign I           = imm_q;
  assign aluc        = aluc_q;
  assign s2          = s2_q;

endmodule

// File: tb/tb_spcore_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spcore_ctrl
// Drives spcore_ctrl with directed and random instruction streams. A
// transaction model expands each accepted instruction into its list of
// expected per-cycle strobes (from the latency table) and an architectural
// register/memory model applies each instruction's effect at retirement.
// A tiny spcore datapath driven by the DUT's outputs is compared against it.
// ---------------------------------------------------------------------------
module tb_spcore_ctrl;
  import spcore_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        instr_ready;
  logic [3:0]  x, y, z, aluc;
  logic [15:0] I;
  logic [1:0]  s2;
  logic        reg_we, mem_we, done, err, halted;

  spcore_ctrl #(.IW(32), .OPW(4)) dut (
    .clk(clk), .reset(reset), .en(en), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .x(x), .y(y), .z(z), .I(I), .aluc(aluc), .s2(s2),
    .reg_we(reg_we), .mem_we(mem_we), .done(done), .err(err), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       reg_we, mem_we, done, err, chk_a, chk_s;
    logic [3:0] aluc;
    logic [1:0] s2;
  } exp_t;

  exp_t        exp_q[$];
  logic [3:0]  m_op, m_x, m_y, m_z;
  logic [15:0] m_imm;
  bit          m_halted = 1'b0;
  logic [31:0] arch_r[16], arch_m[16], dp_r[16], dp_m[16];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic rw, input logic mw, input logic dn, input logic er,
                              input logic ca, input logic [3:0] a, input logic cs, input logic [1:0] s);
    exp_t e;
    e.reg_we = rw; e.mem_we = mw; e.done = dn; e.err = er;
    e.chk_a = ca; e.aluc = a; e.chk_s = cs; e.s2 = s;
    return e;
  endfunction

  function automatic logic [31:0] mkw(input logic [3:0] op, input logic [3:0] xi,
                                      input logic [3:0] yi, input logic [3:0] zi, input logic [15:0] im);
    return {op, xi, yi, zi, im};
  endfunction

  // Expand an accepted instruction into one expected record per active cycle
  task automatic accept(input logic [31:0] w);
    logic [3:0] a;
    m_op = w[31:28]; m_x = w[27:24]; m_y = w[23:20]; m_z = w[19:16]; m_imm = w[15:0];
    exp_q.delete();
    case (m_op)
      OP_LOADI: begin
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUC_CLEAR, 1'b0, MuxD_fromALU));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ALUC_CLEAR, 1'b1, MuxD_fromI));
      end
      OP_ADD, OP_MUL, OP_MAD: begin
        a = (m_op == OP_ADD) ? ALUC_ADD : ((m_op == OP_MUL) ? ALUC_MUL : ALUC_MAD);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUC_CLEAR, 1'b0, MuxD_fromALU));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, 1'b1, MuxD_fromALU));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, a, 1'b1, MuxD_fromALU));
      end
      OP_STORE: begin
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUC_CLEAR, 1'b0, MuxD_fromALU));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ALUC_CLEAR, 1'b0, MuxD_fromALU));
      end
      OP_LOAD: begin
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUC_CLEAR, 1'b0, MuxD_fromALU));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUC_CLEAR, 1'b0, MuxD_fromALU));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALUC_CLEAR, 1'b1, MuxD_fromMem));
      end
      OP_NOP, OP_HALT:
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALUC_CLEAR, 1'b0, MuxD_fromALU));
      default:
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ALUC_CLEAR, 1'b0, MuxD_fromALU));
    endcase
  endtask

  // Architectural effect of the instruction that just retired
  task automatic retire();
    logic [31:0] ry;
    ry = arch_r[m_y];
    case (m_op)
      OP_LOADI: arch_r[m_x] = {16'h0, m_imm};
      OP_ADD:   arch_r[m_x] = arch_r[m_y] + arch_r[m_z];
      OP_MUL:   arch_r[m_x] = arch_r[m_y] * arch_r[m_z];
      OP_MAD:   arch_r[m_x] = arch_r[m_x] + arch_r[m_y] * arch_r[m_z];
      OP_STORE: arch_m[ry[3:0]] = arch_r[m_x];
      OP_LOAD:  arch_r[m_x] = arch_m[ry[3:0]];
      OP_HALT:  m_halted = 1'b1;
      default:  ;
    endcase
  endtask

  // One clock: drive inputs after the edge, check at the falling edge,
  // apply datapath writes and advance the model for the coming edge
  task automatic step(input logic en_v, input logic valid_v, input logic [31:0] w);
    exp_t        r;
    logic [5:0]  ectl;
    logic [31:0] v, ay;
    bit          last;
    @(posedge clk);
    #1;
    en = en_v; instr_valid = valid_v; instr = w;
    @(negedge clk);
    r = '0;
    if (m_halted) begin
      ectl = 6'b000001;
    end else if (exp_q.size() == 0) begin
      ectl = {en_v, 5'b00000};
    end else begin
      r = exp_q[0];
      ectl = {1'b0, r.reg_we & en_v, r.mem_we & en_v, r.done & en_v, r.err & en_v, 1'b0};
    end
    check_eq("ctl{rdy,rwe,mwe,done,err,hlt}", {26'h0, instr_ready, reg_we, mem_we, done, err, halted},
             {26'h0, ectl});
    if (!m_halted && exp_q.size() != 0) begin
      check_eq("fields", {4'h0, x, y, z, I}, {4'h0, m_x, m_y, m_z, m_imm});
      if (r.chk_a) check_eq("aluc", {28'h0, aluc}, {28'h0, r.aluc});
      if (r.chk_s) check_eq("s2", {30'h0, s2}, {30'h0, r.s2});
    end
    ay = dp_r[y];
    if (reg_we) begin
      case (s2)
        MuxD_fromI:   v = {16'h0, I};
        MuxD_fromMem: v = dp_m[ay[3:0]];
        MuxD_fromALU: begin
          case (aluc)
            ALUC_ADD: v = dp_r[y] + dp_r[z];
            ALUC_MUL: v = dp_r[y] * dp_r[z];
            ALUC_MAD: v = dp_r[x] + dp_r[y] * dp_r[z];
            default:  v = 32'h0;
          endcase
        end
        default: v = 32'hdead_beef;
      endcase
      dp_r[x] = v;
    end
    if (mem_we) dp_m[ay[3:0]] = dp_r[x];
    if (en_v && !m_halted) begin
      if (exp_q.size() != 0) begin
        last = (exp_q.size() == 1);
        r = exp_q.pop_front();
        if (last) retire();
      end else if (valid_v) begin
        accept(w);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1'b1, 1'b0, 32'h0);
  endtask

  task automatic run_instr(input logic [31:0] w);
    step(1'b1, 1'b1, w);
    drain();
  endtask

  // Hold reset for some cycles with en and valid high, checking reset values
  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    reset = 1'b0; en = 1'b1; instr_valid = 1'b1; instr = mkw(OP_LOADI, 4'd1, 4'd0, 4'd0, 16'd7);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_eq("rst_ctl", {26'h0, instr_ready, reg_we, mem_we, done, err, halted}, 32'h0);
      check_eq("rst_fields", {4'h0, x, y, z, I}, 32'h0);
      check_eq("rst_aluc_s2", {26'h0, aluc, s2}, {26'h0, ALUC_CLEAR, MuxD_fromALU});
    end
    @(posedge clk);
    #1;
    reset = 1'b1; en = 1'b0; instr_valid = 1'b0;
    exp_q.delete();
    m_halted = 1'b0;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [3:0]  op4;
    for (int i = 0; i < 16; i++) begin
      arch_r[i] = 32'h0; arch_m[i] = 32'h0; dp_r[i] = 32'h0; dp_m[i] = 32'h0;
    end

    do_reset(3);

    // Directed arithmetic sequence
    run_instr(mkw(OP_LOADI, 4'd0, 4'd0, 4'd0, 16'd11));
    check_eq("r0_loadi", dp_r[0], 32'd11);
    run_instr(mkw(OP_LOADI, 4'd1, 4'd0, 4'd0, 16'd20));
    run_instr(mkw(OP_ADD, 4'd2, 4'd0, 4'd1, 16'd0));
    check_eq("r2_add", dp_r[2], 32'd31);
    run_instr(mkw(OP_MAD, 4'd2, 4'd0, 4'd1, 16'd0));
    check_eq("r2_mad", dp_r[2], 32'd251);
    run_instr(mkw(OP_MUL, 4'd2, 4'd0, 4'd1, 16'd0));
    check_eq("r2_mul", dp_r[2], 32'd220);
    run_instr(mkw(OP_STORE, 4'd2, 4'd0, 4'd0, 16'd0));
    check_eq("mem11_store", dp_m[11], 32'd220);
    run_instr(mkw(OP_LOAD, 4'd4, 4'd0, 4'd0, 16'd0));
    check_eq("r4_load", dp_r[4], 32'd220);

    // Stall in EXEC for 3 cycles, with instr_valid noise while busy
    step(1'b1, 1'b1, mkw(OP_ADD, 4'd3, 4'd0, 4'd1, 16'd0));
    step(1'b1, 1'b1, mkw(OP_LOADI, 4'd3, 4'd0, 4'd0, 16'd99));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mkw(OP_LOADI, 4'd3, 4'd0, 4'd0, 16'd99));
    step(1'b1, 1'b1, mkw(OP_LOADI, 4'd3, 4'd0, 4'd0, 16'd99));
    step(1'b1, 1'b1, mkw(OP_LOADI, 4'd3, 4'd0, 4'd0, 16'd99));
    check_eq("r3_add_stall", dp_r[3], 32'd31);
    drain();

    // Random stream (no HALT)
    for (int c = 0; c < 1500; c++) begin
      rnd = $urandom();
      op4 = 4'($urandom_range(0, 14));
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), {op4, rnd[27:0]});
    end
    drain();

    // Reset in the middle of an ADD's EXEC cycle
    step(1'b1, 1'b1, mkw(OP_ADD, 4'd5, 4'd0, 4'd1, 16'd0));
    step(1'b1, 1'b0, 32'h0);
    do_reset(2);
    run_instr(mkw(OP_LOADI, 4'd6, 4'd0, 4'd0, 16'h1234));
    check_eq("r6_after_rst", dp_r[6], 32'h1234);

    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("reg%0d", i), dp_r[i], arch_r[i]);
      check_eq($sformatf("mem%0d", i), dp_m[i], arch_m[i]);
    end

    // Illegal opcode, then HALT and valid held high afterwards
    run_instr(mkw(4'h9, 4'd7, 4'd0, 4'd0, 16'd0));
    run_instr(mkw(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, mkw(OP_LOADI, 4'd8, 4'd0, 4'd0, 16'd5));
    check_eq("halted", {31'h0, halted}, 32'h1);
    check_eq("r8_untouched", dp_r[8], arch_r[8]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
